norm_sequencer: RTL and testbench

Multi-cycle normalization controller for the real-number multiplier back end. It accepts an unnormalized mantissa product and biased exponent over a valid/ready handshake. It counts the mantissa's leading zeros, then left-shifts at most STEP bits per cycle while decrementing the exponent, and delivers a normalized result with zero/underflow flags. It sits between the mantissa multiplier and the rounding/packing stage, and bounds the shifter's per-cycle depth at the cost of latency.

---
 rtl/norm_sequencer_pkg.sv | 20 ++
 rtl/norm_sequencer_if.sv | 27 ++
 rtl/norm_sequencer_zero_counter.sv | 33 +++
 rtl/norm_sequencer.sv | 135 +++++++++++++
 tb/tb_norm_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/norm_sequencer_pkg.sv
// Shared definitions for the normalization sequencer and the rounding stage:
// FSM state encoding and the leading-zero count width derivation.
package norm_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t COUNT = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t DONE  = 2'd3;

  function automatic int lz_width(input int mant_w);
    return $clog2(mant_w + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/norm_sequencer_if.sv
// Operand/result handshake bundle between the mantissa multiplier, the
// normalization sequencer and the rounding/packing stage.
interface norm_sequencer_if #(
  parameter int MANT_W = 16,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_uflow;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );
endinterface

// File: rtl/norm_sequencer_zero_counter.sv
// Combinational zero counter: leading zeros (REVERSE=0) or trailing zeros
// (REVERSE=1); an all-zero input yields IN_W.
module zero_counter #(
  parameter int IN_W    = 16,
  parameter bit REVERSE = 1'b0
) (
  input  logic [IN_W-1:0]            data,
  output logic [$clog2(IN_W+1)-1:0]  count
);
  localparam int CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0] scan_s;
  logic            found_s;

  // Priority scan from the top of the (optionally bit-reversed) word.
  always_comb begin
    scan_s  = '0;
    count   = CNT_W'(IN_W);
    found_s = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      scan_s[i] = REVERSE ? data[IN_W-1-i] : data[i];
    end
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!found_s && scan_s[i]) begin
        count   = CNT_W'(IN_W - 1 - i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/norm_sequencer.sv
// Multi-cycle mantissa normalizer: counts leading zeros once, then shifts at
// most STEP bits per cycle while decrementing the exponent (clamped at 0).
module norm_sequencer
  import norm_sequencer_pkg::*;
#(
  parameter int MANT_W = 16,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  norm_sequencer_if.slave  bus
);
  localparam int LZ_W  = lz_width(MANT_W);
  localparam int CMP_W = max_int(LZ_W, EXP_W);
  localparam int S_W   = $clog2(STEP + 1);

  state_t            state_r;
  logic [MANT_W-1:0] mant_r;
  logic [EXP_W-1:0]  exp_r;
  logic [LZ_W-1:0]   rem_r;
  logic              zero_r;
  logic              uflow_r;

  logic [LZ_W-1:0]   lz_s;
  logic [CMP_W-1:0]  lz_ext_s;
  logic [CMP_W-1:0]  exp_ext_s;
  logic [CMP_W-1:0]  shift_ext_s;
  logic              uflow_s;
  logic [LZ_W-1:0]   rem_init_s;
  logic [S_W-1:0]    step_s;
  logic [MANT_W-1:0] shifted_s;
  logic [LZ_W-1:0]   rem_next_s;
  logic [EXP_W-1:0]  exp_next_s;

  zero_counter #(
    .IN_W    (MANT_W),
    .REVERSE (1'b0)
  ) u_zero_counter (
    .data  (mant_r),
    .count (lz_s)
  );

  // Shift amount for COUNT: min(lz, exp), compared zero-extended so the
  // exponent clamp never lets exp wrap below zero.
  always_comb begin
    lz_ext_s    = CMP_W'(lz_s);
    exp_ext_s   = CMP_W'(exp_r);
    uflow_s     = (lz_ext_s >= exp_ext_s);
    shift_ext_s = uflow_s ? exp_ext_s : lz_ext_s;
    rem_init_s  = LZ_W'(shift_ext_s);
  end

  // One SHIFT step: s = min(STEP, rem) applied through a log2(STEP)+1 level barrel.
  always_comb begin
    if (rem_r > LZ_W'(STEP)) begin
      step_s = S_W'(STEP);
    end else begin
      step_s = S_W'(rem_r);
    end
    shifted_s = mant_r;
    for (int k = 0; k < S_W; k++) begin
      if (step_s[k]) begin
        shifted_s = shifted_s << (1 << k);
      end else begin
        shifted_s = shifted_s;
      end
    end
    rem_next_s = rem_r - LZ_W'(step_s);
    exp_next_s = exp_r - EXP_W'(step_s);
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mant_r  <= '0;
      exp_r   <= '0;
      rem_r   <= '0;
      zero_r  <= 1'b0;
      uflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            mant_r  <= bus.in_mant;
            exp_r   <= bus.in_exp;
            rem_r   <= '0;
            zero_r  <= 1'b0;
            uflow_r <= 1'b0;
            state_r <= COUNT;
          end
        end
        COUNT: begin
          if (mant_r == '0) begin
            exp_r   <= '0;
            rem_r   <= '0;
            zero_r  <= 1'b1;
            uflow_r <= 1'b0;
            state_r <= DONE;
          end else begin
            rem_r   <= rem_init_s;
            uflow_r <= uflow_s;
            state_r <= (rem_init_s == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          mant_r <= shifted_s;
          exp_r  <= exp_next_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == '0) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags come from the state register, forced low while in reset.
  assign bus.in_ready  = (state_r == IDLE) & ~rst;
  assign bus.out_valid = (state_r == DONE) & ~rst;
  assign bus.out_mant  = mant_r;
  assign bus.out_exp   = exp_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_uflow = uflow_r;

endmodule

// File: tb/tb_norm_sequencer.sv
// Table-driven bench for norm_sequencer with a result scoreboard plus
// hand-written backpressure and mid-operation reset sequences.
module tb_norm_sequencer;
  localparam int MANT_W = 16;
  localparam int EXP_W  = 8;
  localparam int STEP   = 4;
  localparam int NVEC   = 10;

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  exp;
    logic [15:0] e_mant;
    logic [7:0]  e_exp;
    logic        e_zero;
    logic        e_uflow;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs [NVEC];
  vec_t sb [$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  norm_sequencer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  norm_sequencer #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand in an IDLE cycle; returns in cycle 1 (after accept edge).
  task automatic send(input vec_t v);
    check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mant  = v.mant;
    bus.in_exp   = v.exp;
    sb.push_back(v);
    tick();
    bus.in_valid = 1'b0;
    bus.in_mant  = 16'h0000;
    bus.in_exp   = 8'h00;
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head.
  task automatic collect(input string tag);
    int   cyc;
    vec_t e;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_scoreboard: got result, expected none pending", tag);
      end else begin
        e = sb.pop_front();
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_mant"},  {16'd0, bus.out_mant},  {16'd0, e.e_mant});
        check({tag, "_exp"},   {24'd0, bus.out_exp},   {24'd0, e.e_exp});
        check({tag, "_zero"},  {31'd0, bus.out_zero},  {31'd0, e.e_zero});
        check({tag, "_uflow"}, {31'd0, bus.out_uflow}, {31'd0, e.e_uflow});
      end
    end
  endtask

  initial begin
    int stray;
    //           mant      exp     e_mant    e_exp   z     u     lat
    vecs[0] = '{16'h8000, 8'd10,  16'h8000, 8'd10,  1'b0, 1'b0, 2};
    vecs[1] = '{16'h0001, 8'd20,  16'h8000, 8'd5,   1'b0, 1'b0, 6};
    vecs[2] = '{16'h0010, 8'd5,   16'h0200, 8'd0,   1'b0, 1'b1, 4};
    vecs[3] = '{16'h0000, 8'd77,  16'h0000, 8'd0,   1'b1, 1'b0, 2};
    vecs[4] = '{16'h8000, 8'd0,   16'h8000, 8'd0,   1'b0, 1'b1, 2};
    vecs[5] = '{16'h00F0, 8'd100, 16'hF000, 8'd92,  1'b0, 1'b0, 4};
    vecs[6] = '{16'h0003, 8'd14,  16'hC000, 8'd0,   1'b0, 1'b1, 6};
    vecs[7] = '{16'h4000, 8'd1,   16'h8000, 8'd0,   1'b0, 1'b1, 3};
    vecs[8] = '{16'h0800, 8'd255, 16'h8000, 8'd251, 1'b0, 1'b0, 3};
    vecs[9] = '{16'h1234, 8'd3,   16'h91A0, 8'd0,   1'b0, 1'b1, 3};

    bus.in_valid  = 1'b0;
    bus.in_mant   = 16'h0000;
    bus.in_exp    = 8'h00;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) tick();
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_mant",  {16'd0, bus.out_mant},  32'd0);
    check("rst_out_exp",   {24'd0, bus.out_exp},   32'd0);
    check("rst_out_zero",  {31'd0, bus.out_zero},  32'd0);
    check("rst_out_uflow", {31'd0, bus.out_uflow}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
    tick();

    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i]);
      collect($sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d_idle_out_valid", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: result held for 5 cycles, stray in_valid ignored.
    bus.out_ready = 1'b0;
    send(vecs[0]);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1);
      bus.in_mant  = 16'h0001;
      bus.in_exp   = 8'd20;
      tick();
      check("bp_hold_valid",  {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_hold_mant",   {16'd0, bus.out_mant},  32'h8000);
      check("bp_hold_exp",    {24'd0, bus.out_exp},   32'd10);
      check("bp_hold_uflow",  {31'd0, bus.out_uflow}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    stray = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid) stray++;
    end
    check("bp_stray_results", stray, 0);

    // Reset asserted during SHIFT of the deep-shift operand.
    send(vecs[1]);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    check("post_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    stray = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid) stray++;
    end
    check("post_rst_stray_results", stray, 0);
    send(vecs[0]);
    collect("after_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
